// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI slave controller.
package spi_pkg;
  localparam int SPI_MODE0  = 0;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detection on the
// synchronized value.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;
endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave clocked by the system clock: oversampled pins, MSB-first
// word deserializer/serializer with valid/ready TX and strobed RX.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int                 DATA_W      = DEF_DATA_W,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  TX_DEFAULT  = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cs_b,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W-1);

  // pin index: 0 = cs_b, 1 = sclk, 2 = mosi
  logic [2:0] pin_in, pin_s, pin_rise, pin_fall;
  assign pin_in = {mosi, sclk, cs_b};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    spi_pin_sync #(
      .STAGES (SYNC_STAGES),
      .RST_VAL(i == 0)
    ) u_sync (
      .clk  (clk),
      .rst_b(rst_b),
      .din  (pin_in[i]),
      .dout (pin_s[i]),
      .rise (pin_rise[i]),
      .fall (pin_fall[i])
    );
  end

  logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;
  assign cs_rise   = pin_rise[0];
  assign cs_fall   = pin_fall[0];
  assign sclk_rise = pin_rise[1];
  assign sclk_fall = pin_fall[1];
  assign mosi_s    = pin_s[2];

  logic unused_pins;
  assign unused_pins = ^{pin_s[1:0], pin_rise[2], pin_fall[2]};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              rx_pend_q, rx_pend_d;
  logic              rx_valid_q, rx_valid_d;
  logic              abort_q, abort_d;
  logic              load;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    rx_pend_d  = 1'b0;
    rx_valid_d = rx_pend_q;
    abort_d    = 1'b0;
    load       = 1'b0;

    if (cs_rise) begin
      // cs_b rise wins over any sclk edge seen in the same cycle
      state_d    = ST_IDLE;
      oe_d       = 1'b0;
      miso_d     = 1'b0;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      abort_d    = (bit_cnt_q != '0);
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_LOAD;
        ST_LOAD: begin
          load    = 1'b1;
          oe_d    = 1'b1;
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              // reload now so the next MSB is on miso before the next rise
              bit_cnt_d = '0;
              rx_data_d = rx_shift_d;
              rx_pend_d = 1'b1;
              load      = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall && bit_cnt_q != '0) begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[DATA_W-2];
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (load) begin
        tx_shift_d = tx_valid ? tx_data : TX_DEFAULT;
        miso_d     = tx_shift_d[DATA_W-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_pend_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      rx_pend_q  <= rx_pend_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = oe_q;
  assign busy        = oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_abort = abort_q;
  assign tx_ready    = load & tx_valid;
  assign tx_underrun = load & ~tx_valid;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Randomized SPI master bench for spi_slave_ctrl with a word-level reference model.
module tb_spi_slave_ctrl;
  localparam int S = 2;
  localparam logic [7:0] TXD = 8'hFF;

  logic       clk = 0, rst_b = 0;
  logic       cs_b = 1, sclk = 0, mosi = 0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, busy;
  logic [7:0] tx_data = 0, rx_data;
  logic       tx_valid = 0;

  spi_slave_ctrl #(.DATA_W(8), .SYNC_STAGES(S), .TX_DEFAULT(TXD)) dut (
    .clk(clk), .rst_b(rst_b), .cs_b(cs_b), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_rx, n_rdy, n_und, n_abt;
  logic oe_seen;
  logic [7:0] txq[$], mq[$], rxq[$];
  logic [7:0] mosi_w [0:3];
  logic [7:0] rd_w [0:3];
  logic [7:0] last_rx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tx_refresh();
    tx_valid = (txq.size() > 0);
    tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
  endtask

  task automatic push_tx(input logic [7:0] v);
    txq.push_back(v);
    mq.push_back(v);
    tx_refresh();
  endtask

  // host side: drop the head word after the cycle in which it was consumed
  initial forever begin
    @(negedge clk);
    if (tx_ready === 1'b1) begin
      @(posedge clk); #1;
      void'(txq.pop_front());
      tx_refresh();
    end
  end

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin n_rx++; rxq.push_back(rx_data); end
    if (tx_ready === 1'b1) n_rdy++;
    if (tx_underrun === 1'b1) n_und++;
    if (frame_abort === 1'b1) n_abt++;
    if (miso_oe === 1'b1) oe_seen = 1'b1;
  end

  task automatic clr_mon();
    n_rx = 0; n_rdy = 0; n_und = 0; n_abt = 0; oe_seen = 0; rxq.delete();
  endtask

  // one mode-0 bit: master samples miso and raises sclk, holds 5 clk each phase
  task automatic do_bit(input logic mo, output logic mi);
    mosi = mo;
    repeat (2) @(negedge clk);
    mi = miso;
    sclk = 1;
    repeat (5) @(negedge clk);
    sclk = 0;
    repeat (3) @(negedge clk);
  endtask

  // nw full words, then ab bits of an aborted word (ab=0: clean end)
  task automatic run_frame(input int nw, input int ab);
    int loads, exp_rdy, exp_und, lo;
    logic b;
    logic [7:0] v;
    clr_mon();
    for (int w = 0; w < 4; w++) rd_w[w] = 8'h00;
    @(negedge clk);
    cs_b = 0;
    repeat (10) @(negedge clk);
    chk("busy_on", {31'd0, busy}, 32'd1);
    for (int w = 0; w < nw + (ab > 0 ? 1 : 0); w++) begin
      lo = (w == nw) ? 8 - ab : 0;
      for (int i = 7; i >= lo; i--) begin
        do_bit(mosi_w[w][i], b);
        rd_w[w][i] = b;
      end
    end
    repeat (2) @(negedge clk);
    cs_b = 1;
    repeat (S + 2) @(posedge clk);
    #1;
    chk("oe_off", {31'd0, miso_oe}, 32'd0);
    chk("busy_off", {31'd0, busy}, 32'd0);
    repeat (8) @(negedge clk);
    // initial load plus one reload per completed word
    loads = nw + 1; exp_rdy = 0; exp_und = 0;
    for (int i = 0; i < loads; i++) begin
      if (mq.size() > 0) begin v = mq.pop_front(); exp_rdy++; end
      else begin v = TXD; exp_und++; end
      if (i < nw) chk("miso_word", {24'd0, rd_w[i]}, {24'd0, v});
      if (i == nw && ab > 0)
        chk("miso_part", {24'd0, rd_w[i] >> (8 - ab)}, {24'd0, v >> (8 - ab)});
    end
    chk("rx_cnt", n_rx, nw);
    for (int i = 0; i < nw && i < rxq.size(); i++)
      chk("rx_word", {24'd0, rxq[i]}, {24'd0, mosi_w[i]});
    chk("tx_ready_cnt", n_rdy, exp_rdy);
    chk("underrun_cnt", n_und, exp_und);
    chk("abort_cnt", n_abt, (ab > 0) ? 1 : 0);
    if (nw > 0) last_rx = mosi_w[nw - 1];
    chk("rx_hold", {24'd0, rx_data}, {24'd0, last_rx});
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic b;
    last_rx = 8'h00;
    clr_mon();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_strobes", {28'd0, rx_valid, tx_ready, tx_underrun, frame_abort}, 32'd0);
    rst_b = 1;
    repeat (5) @(negedge clk);

    // single word
    push_tx(8'hA5); mosi_w[0] = 8'h3C;
    run_frame(1, 0);
    // burst of three
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
    mosi_w[0] = 8'hF0; mosi_w[1] = 8'hF1; mosi_w[2] = 8'hF2;
    run_frame(3, 0);
    // underrun: nothing queued
    mosi_w[0] = 8'h77;
    run_frame(1, 0);
    // abort after 5 bits
    mosi_w[0] = 8'h99;
    run_frame(0, 5);

    // idle noise with cs_b high
    clr_mon();
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom);
      sclk = 1; repeat (3) @(negedge clk);
      sclk = 0; repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("noise_rx", n_rx, 0);
    chk("noise_oe", {31'd0, oe_seen}, 32'd0);
    chk("noise_load", n_rdy + n_und, 0);

    // reset mid-frame, nothing queued
    @(negedge clk);
    cs_b = 0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) do_bit(1'b1, b);
    rst_b = 0;
    #1;
    chk("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
    chk("mid_rst_miso", {31'd0, miso}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("mid_rst_strobes", {28'd0, rx_valid, tx_ready, tx_underrun, frame_abort}, 32'd0);
    cs_b = 1; sclk = 0;
    repeat (3) @(negedge clk);
    rst_b = 1;
    last_rx = 8'h00;
    repeat (5) @(negedge clk);
    push_tx(8'h5A); mosi_w[0] = 8'hC3;
    run_frame(1, 0);

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      int nw, k, ab;
      nw = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0 || nw == 0) ? $urandom_range(1, 7) : 0;
      k  = $urandom_range(0, nw + 1);
      for (int i = 0; i < k; i++) push_tx(8'($urandom));
      for (int i = 0; i < 4; i++) mosi_w[i] = 8'($urandom);
      run_frame(nw, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
